// File: rtl/switch_pkg.sv
// Shared types and helpers for the four-port packet switch.
package switch_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int PKT_DATA_W = 8;

  typedef logic [NUM_PORTS-1:0] port_mask_t;

  typedef struct packed {
    port_mask_t            source;
    port_mask_t            target;
    port_mask_t            mask;
    logic [PKT_DATA_W-1:0] data;
  } pkt_t;

  function automatic port_mask_t onehot_of(input int idx);
    return port_mask_t'(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/port_if.sv
// Per-port bundle: ingress fields driven by the endpoint, egress fields driven by the switch.
interface port_if #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n
);
  import switch_pkg::*;

  logic              valid_in;
  port_mask_t        source_in;
  port_mask_t        target_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  port_mask_t        source_out;
  port_mask_t        target_out;
  logic [DATA_W-1:0] data_out;

  modport sw (
    input  clk, rst_n, valid_in, source_in, target_in, data_in,
    output valid_out, source_out, target_out, data_out
  );
endinterface

// File: rtl/switch_rr_arbiter.sv
// Four-request round-robin arbiter; pointer moves to one past the granted request.
module switch_rr_arbiter
  import switch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  port_mask_t req_i,
  output port_mask_t gnt_o
);
  logic [1:0] ptr_q, ptr_d, idx;

  // Scan from the highest offset down so the nearest request at or after ptr wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx = ptr_q + 2'(off);
      if (req_i[idx]) begin
        gnt_o = onehot_of(int'(idx));
        ptr_d = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/switch_4port.sv
// Four-port packet switch: per-ingress FIFOs, per-output round-robin arbiters, grant and output
// register stages. Define SWITCH_LOOPBACK_EN to let a packet be delivered back to its sender.
module switch_4port
  import switch_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  port_if.sw  port0,
  port_if.sw  port1,
  port_if.sw  port2,
  port_if.sw  port3
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    port_mask_t        source;
    port_mask_t        target;
    port_mask_t        mask;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_PORTS-1:0] vin, push, pop, hvld;
  port_mask_t           src_in [NUM_PORTS];
  port_mask_t           tgt_in [NUM_PORTS];
  logic [DATA_W-1:0]    dat_in [NUM_PORTS];

  assign vin       = {port3.valid_in, port2.valid_in, port1.valid_in, port0.valid_in};
  assign src_in[0] = port0.source_in;
  assign src_in[1] = port1.source_in;
  assign src_in[2] = port2.source_in;
  assign src_in[3] = port3.source_in;
  assign tgt_in[0] = port0.target_in;
  assign tgt_in[1] = port1.target_in;
  assign tgt_in[2] = port2.target_in;
  assign tgt_in[3] = port3.target_in;
  assign dat_in[0] = port0.data_in;
  assign dat_in[1] = port1.data_in;
  assign dat_in[2] = port2.data_in;
  assign dat_in[3] = port3.data_in;

  entry_t        mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q [NUM_PORTS];
  logic [AW-1:0] wr_ptr_q [NUM_PORTS];
  logic [AW:0]   cnt_q    [NUM_PORTS];
  logic [AW:0]   cnt_d    [NUM_PORTS];
  entry_t        head     [NUM_PORTS];
  port_mask_t    eff_mask [NUM_PORTS];
  port_mask_t    taken    [NUM_PORTS];
  port_mask_t    rem_mask [NUM_PORTS];
  port_mask_t    req      [NUM_PORTS];
  port_mask_t    gnt      [NUM_PORTS];

  // Ingress: the head's stored mask doubles as its pending-delivery mask.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef SWITCH_LOOPBACK_EN
      eff_mask[i] = tgt_in[i];
`else
      eff_mask[i] = tgt_in[i] & ~onehot_of(i);
`endif
      push[i] = vin[i] && (eff_mask[i] != '0) && (cnt_q[i] != (AW+1)'(FIFO_DEPTH));
      hvld[i] = (cnt_q[i] != '0);
      head[i] = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) req[o][i] = hvld[i] & head[i].mask[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    switch_rr_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req[o]),
      .gnt_o (gnt[o])
    );
  end

  // Full-FIFO check uses the current count, so a same-cycle pop never makes room for a write.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      taken[i] = '0;
      for (int o = 0; o < NUM_PORTS; o++) taken[i][o] = gnt[o][i];
      rem_mask[i] = head[i].mask & ~taken[i];
      pop[i]      = hvld[i] && (taken[i] != '0) && (rem_mask[i] == '0);
      cnt_d[i]    = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end

  port_mask_t        gnt_src_d [NUM_PORTS];
  port_mask_t        gnt_tgt_d [NUM_PORTS];
  logic [DATA_W-1:0] gnt_dat_d [NUM_PORTS];

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_src_d[o] = '0;
      gnt_tgt_d[o] = '0;
      gnt_dat_d[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[o][i]) begin
          gnt_src_d[o] = head[i].source;
          gnt_tgt_d[o] = head[i].target;
          gnt_dat_d[o] = head[i].data;
        end
      end
    end
  end

  logic [NUM_PORTS-1:0] gnt_vld_q, out_vld_q;
  port_mask_t           gnt_src_q [NUM_PORTS];
  port_mask_t           gnt_tgt_q [NUM_PORTS];
  logic [DATA_W-1:0]    gnt_dat_q [NUM_PORTS];
  port_mask_t           out_src_q [NUM_PORTS];
  port_mask_t           out_tgt_q [NUM_PORTS];
  logic [DATA_W-1:0]    out_dat_q [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_vld_q <= '0;
      out_vld_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_ptr_q[i]  <= '0;
        wr_ptr_q[i]  <= '0;
        cnt_q[i]     <= '0;
        out_src_q[i] <= '0;
        out_tgt_q[i] <= '0;
        out_dat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_d[i];
      end
      // Grant stage feeds the output register one cycle later.
      for (int o = 0; o < NUM_PORTS; o++) begin
        gnt_vld_q[o] <= (gnt[o] != '0);
        out_vld_q[o] <= gnt_vld_q[o];
        if (gnt_vld_q[o]) begin
          out_src_q[o] <= gnt_src_q[o];
          out_tgt_q[o] <= gnt_tgt_q[o];
          out_dat_q[o] <= gnt_dat_q[o];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= '{source: src_in[i], target: tgt_in[i],
                                             mask: eff_mask[i], data: dat_in[i]};
      if (hvld[i] && (taken[i] != '0) && !pop[i]) mem_q[i][rd_ptr_q[i]].mask <= rem_mask[i];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt[o] != '0) begin
        gnt_src_q[o] <= gnt_src_d[o];
        gnt_tgt_q[o] <= gnt_tgt_d[o];
        gnt_dat_q[o] <= gnt_dat_d[o];
      end
    end
  end

  assign port0.valid_out  = out_vld_q[0];
  assign port0.source_out = out_src_q[0];
  assign port0.target_out = out_tgt_q[0];
  assign port0.data_out   = out_dat_q[0];
  assign port1.valid_out  = out_vld_q[1];
  assign port1.source_out = out_src_q[1];
  assign port1.target_out = out_tgt_q[1];
  assign port1.data_out   = out_dat_q[1];
  assign port2.valid_out  = out_vld_q[2];
  assign port2.source_out = out_src_q[2];
  assign port2.target_out = out_tgt_q[2];
  assign port2.data_out   = out_dat_q[2];
  assign port3.valid_out  = out_vld_q[3];
  assign port3.source_out = out_src_q[3];
  assign port3.target_out = out_tgt_q[3];
  assign port3.data_out   = out_dat_q[3];
endmodule

// File: tb/tb_switch_4port.sv
// Self-checking bench for switch_4port: directed scenarios plus randomized traffic against a queue model.
module tb_switch_4port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_if #(.DATA_W(8)) p0 (.clk(clk), .rst_n(rst_n));
  port_if #(.DATA_W(8)) p1 (.clk(clk), .rst_n(rst_n));
  port_if #(.DATA_W(8)) p2 (.clk(clk), .rst_n(rst_n));
  port_if #(.DATA_W(8)) p3 (.clk(clk), .rst_n(rst_n));

  switch_4port #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .port0(p0), .port1(p1), .port2(p2), .port3(p3)
  );

  logic [3:0] vin = '0;
  logic [3:0] sin [4];
  logic [3:0] tin [4];
  logic [7:0] din [4];
  logic [3:0] vout;
  logic [3:0] sout [4];
  logic [3:0] tout [4];
  logic [7:0] dout [4];

  assign p0.valid_in = vin[0]; assign p0.source_in = sin[0]; assign p0.target_in = tin[0]; assign p0.data_in = din[0];
  assign p1.valid_in = vin[1]; assign p1.source_in = sin[1]; assign p1.target_in = tin[1]; assign p1.data_in = din[1];
  assign p2.valid_in = vin[2]; assign p2.source_in = sin[2]; assign p2.target_in = tin[2]; assign p2.data_in = din[2];
  assign p3.valid_in = vin[3]; assign p3.source_in = sin[3]; assign p3.target_in = tin[3]; assign p3.data_in = din[3];
  assign vout[0] = p0.valid_out; assign sout[0] = p0.source_out; assign tout[0] = p0.target_out; assign dout[0] = p0.data_out;
  assign vout[1] = p1.valid_out; assign sout[1] = p1.source_out; assign tout[1] = p1.target_out; assign dout[1] = p1.data_out;
  assign vout[2] = p2.valid_out; assign sout[2] = p2.source_out; assign tout[2] = p2.target_out; assign dout[2] = p2.data_out;
  assign vout[3] = p3.valid_out; assign sout[3] = p3.source_out; assign tout[3] = p3.target_out; assign dout[3] = p3.data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         o;
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
  } rec_t;
  rec_t rx_q[$];
  rec_t mon_r;

  // Every delivery pulse is logged with the edge count it followed.
  always @(negedge clk) begin
    for (int o = 0; o < 4; o++) begin
      if (vout[o] === 1'b1) begin
        mon_r.cyc = cyc; mon_r.o = o; mon_r.src = sout[o]; mon_r.tgt = tout[o]; mon_r.data = dout[o];
        rx_q.push_back(mon_r);
      end
    end
  end

  typedef struct {
    logic [3:0] tgt;
    logic [7:0] data;
  } exp_t;
  exp_t expq [4][4][$];

  // Delivery set of a packet sent on port p with target t.
  function automatic logic [3:0] eff(int p, logic [3:0] t);
    logic [3:0] own;
    own = 4'b0001 << p;
`ifdef SWITCH_LOOPBACK_EN
    return t;
`else
    return t & ~own;
`endif
  endfunction

  task automatic set_port(int p, logic v, logic [3:0] t, logic [7:0] d);
    vin[p] = v; sin[p] = 4'b0001 << p; tin[p] = t; din[p] = d;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) set_port(p, 1'b0, 4'b0000, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int o = 0; o < 4; o++) begin
      checks++;
      if (vout[o] !== 1'b0 || sout[o] !== 4'h0 || tout[o] !== 4'h0 || dout[o] !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold port%0d: got v=%b s=%h t=%h d=%h, want all 0", o, vout[o], sout[o], tout[o], dout[o]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int o = 0; o < 4; o++) begin
      checks++;
      if (vout[o] !== 1'b0 || dout[o] !== 8'h00) begin
        errors++;
        $display("FAIL reset_release port%0d: got v=%b d=%h, want 0", o, vout[o], dout[o]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) set_port(p, 1'b1, 4'b1000, 8'(8'h40 + c * 4 + p));
    end
    @(negedge clk) idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int o = 0; o < 4; o++) begin
      checks++;
      if (vout[o] !== 1'b0 || sout[o] !== 4'h0 || tout[o] !== 4'h0 || dout[o] !== 8'h00) begin
        errors++;
        $display("FAIL reset_async port%0d: got v=%b s=%h t=%h d=%h, want all 0", o, vout[o], sout[o], tout[o], dout[o]);
      end
    end
    rx_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL reset_flush: got %0d deliveries after reset, want 0", rx_q.size());
    end
  endtask

  task automatic test_single(string nm, int p, logic [3:0] t, logic [7:0] d);
    int n;
    int cnt [4];
    logic [3:0] em;
    logic [3:0] sx;
    rx_q.delete();
    @(negedge clk) set_port(p, 1'b1, t, d);
    @(posedge clk);
    #1 n = cyc;
    idle_inputs();
    repeat (6) @(negedge clk);
    #1;
    em = eff(p, t);
    sx = 4'b0001 << p;
    for (int o = 0; o < 4; o++) cnt[o] = 0;
    foreach (rx_q[k]) begin
      cnt[rx_q[k].o]++;
      checks++;
      if (!em[rx_q[k].o] || rx_q[k].cyc != n + 2 || rx_q[k].data !== d || rx_q[k].src !== sx || rx_q[k].tgt !== t) begin
        errors++;
        $display("FAIL %s port%0d: got cyc=%0d src=%h tgt=%h data=%h, want cyc=%0d src=%h tgt=%h data=%h targeted=%b",
                 nm, rx_q[k].o, rx_q[k].cyc, rx_q[k].src, rx_q[k].tgt, rx_q[k].data, n + 2, sx, t, d, em[rx_q[k].o]);
      end
    end
    for (int o = 0; o < 4; o++) begin
      checks++;
      if (cnt[o] != (em[o] ? 1 : 0)) begin
        errors++;
        $display("FAIL %s_count port%0d: got %0d pulses, want %0d", nm, o, cnt[o], em[o] ? 1 : 0);
      end
    end
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    rx_q.delete();
    @(negedge clk);
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 4'b1000, 8'(8'h10 + p));
    @(posedge clk);
    #1 n = cyc;
    idle_inputs();
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL contention_count: got %0d deliveries, want 3", rx_q.size());
    end
    for (int k = 0; k < rx_q.size() && k < 3; k++) begin
      checks++;
      if (rx_q[k].o != 3 || rx_q[k].cyc != n + 2 + k || rx_q[k].data !== 8'(8'h10 + k) || rx_q[k].src !== 4'(1 << k)) begin
        errors++;
        $display("FAIL contention_order #%0d: got port%0d cyc=%0d data=%h src=%h, want port3 cyc=%0d data=%h src=%h",
                 k, rx_q[k].o, rx_q[k].cyc, rx_q[k].data, rx_q[k].src, n + 2 + k, 8'(8'h10 + k), 4'(1 << k));
      end
    end
  endtask

  task automatic test_fifo_full();
    int total;
    int last [3];
    int seen [3];
    int p;
    do_reset();
    rx_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int q = 0; q < 3; q++) set_port(q, 1'b1, 4'b1000, 8'(q * 64 + c));
    end
    @(negedge clk) idle_inputs();
    repeat (40) @(negedge clk);
    #1;
    total = 0;
    for (int q = 0; q < 3; q++) begin last[q] = -1; seen[q] = 0; end
    foreach (rx_q[k]) begin
      p = -1;
      for (int q = 0; q < 3; q++) if (rx_q[k].src === 4'(1 << q)) p = q;
      checks++;
      if (rx_q[k].o != 3 || p < 0 || int'(rx_q[k].data[7:6]) != p || int'(rx_q[k].data[5:0]) <= last[p]
          || (seen[p] < 4 && int'(rx_q[k].data[5:0]) != seen[p])) begin
        errors++;
        $display("FAIL full_stream #%0d: got port%0d src=%h data=%h, want port3 in-order data from its source",
                 k, rx_q[k].o, rx_q[k].src, rx_q[k].data);
      end else begin
        last[p] = int'(rx_q[k].data[5:0]);
        seen[p]++;
        total++;
      end
    end
    checks++;
    if (total < 12 || total > 20) begin
      errors++;
      $display("FAIL full_drop: got %0d delivered of 24 sent, want 12..20", total);
    end
  endtask

  task automatic test_random();
    logic v;
    logic [3:0] t;
    logic [7:0] d;
    logic [3:0] em;
    exp_t e;
    int i;
    do_reset();
    rx_q.delete();
    for (int o = 0; o < 4; o++) for (int q = 0; q < 4; q++) expq[o][q].delete();
    for (int b = 0; b < 30; b++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
          v = 1'($urandom_range(0, 1));
          t = 4'($urandom);
          d = 8'($urandom);
          set_port(p, v, t, d);
          em = eff(p, t);
          if (v) for (int o = 0; o < 4; o++) if (em[o]) begin
            e.tgt = t; e.data = d;
            expq[o][p].push_back(e);
          end
        end
      end
      @(negedge clk) idle_inputs();
      repeat (12) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    #1;
    foreach (rx_q[k]) begin
      i = -1;
      for (int q = 0; q < 4; q++) if (rx_q[k].src === 4'(1 << q)) i = q;
      checks++;
      if (i < 0 || expq[rx_q[k].o][i].size() == 0) begin
        errors++;
        $display("FAIL random_unexpected port%0d: got src=%h tgt=%h data=%h, want no such delivery",
                 rx_q[k].o, rx_q[k].src, rx_q[k].tgt, rx_q[k].data);
      end else begin
        e = expq[rx_q[k].o][i].pop_front();
        if (rx_q[k].tgt !== e.tgt || rx_q[k].data !== e.data) begin
          errors++;
          $display("FAIL random_data port%0d src%0d: got tgt=%h data=%h, want tgt=%h data=%h",
                   rx_q[k].o, i, rx_q[k].tgt, rx_q[k].data, e.tgt, e.data);
        end
      end
    end
    for (int o = 0; o < 4; o++) for (int q = 0; q < 4; q++) begin
      checks++;
      if (expq[o][q].size() != 0) begin
        errors++;
        $display("FAIL random_lost port%0d src%0d: got %0d undelivered, want 0", o, q, expq[o][q].size());
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single("unicast", 0, 4'b0010, 8'hA1);
    test_single("multicast", 0, 4'b0110, 8'hB2);
    test_single("broadcast", 0, 4'b1111, 8'hC3);
    test_single("non_p0", 2, 4'b1000, 8'hD4);
    test_contention();
    test_fifo_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
